// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the two handshake ports of the fetch stage.
//   imem_*  pipelined req/gnt/rvalid instruction-memory port
//           (req/addr from the stage, gnt/rvalid/rdata from memory)
//   if_*    valid/ready instruction port towards decode
// Handshake semantics: a request transfers when imem_req && imem_gnt
// in the same cycle; once raised, imem_req and imem_addr stay stable
// until granted unless a flush intervenes. A response arrives as a
// one-cycle imem_rvalid pulse, in request order, at least one cycle
// after its grant. An instruction transfers to decode when
// if_valid && if_ready; if_instr/if_pc hold while if_valid && !if_ready.
// modport master: the fetch stage. modport slave: memory + decode side.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage between the PC and decode.
// Turns pc_addr into requests on the imem port, holds the PC with
// pc_stall until a request is granted, pairs returned words with their
// fetch address in a 2-entry buffer and offers them to decode. flush
// (taken jump) empties the buffer and discards in-flight responses.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   pc_addr    current PC value (also the request address)
//   pc_stall   hold the PC this cycle
//   flush      jump taken this cycle
//   bus        fetch_stage_if.master (imem_* and if_* handshakes)
//   dbg_outst  in-flight request count
//   dbg_count  buffered instruction count
//   dbg_drop   responses still to be discarded
module fetch_stage (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc_addr,
  output logic          pc_stall,
  input  logic          flush,
  fetch_stage_if.master bus,
  output logic [1:0]    dbg_outst,
  output logic [1:0]    dbg_count,
  output logic [1:0]    dbg_drop
);
  // Total credits: in-flight requests plus buffered instructions.
  localparam int DEPTH = 2;

  logic [1:0]  outst;
  logic [1:0]  count;
  logic [1:0]  drop;

  // Address FIFO of granted requests, used to tag each response.
  logic [31:0] afifo [2];
  logic        a_wp, a_rp;

  // Instruction buffer of {pc, instr}.
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        b_wp, b_rp;

  logic        pop;
  logic        grant;
  logic        resp;
  logic        wr;
  logic        rd;
  logic [2:0]  credit_used;

  assign pop  = bus.if_valid && bus.if_ready;
  // A pop this cycle frees a credit immediately, so a full buffer with
  // decode accepting still requests every cycle.
  assign credit_used = {1'b0, outst} + {1'b0, count} - {2'b0, pop};

  // Gated by rst so no request is raised while held in reset.
  assign bus.imem_req  = rst && !flush && (credit_used < 3'(DEPTH));
  assign bus.imem_addr = pc_addr;
  assign grant    = bus.imem_req && bus.imem_gnt;
  assign pc_stall = !flush && !grant;

  // A response with nothing outstanding is spurious and ignored.
  assign resp = bus.imem_rvalid && (outst != 2'd0);
  // The word arriving in a flush cycle is discarded along with the rest.
  assign wr   = resp && (drop == 2'd0) && !flush;
  assign rd   = pop && !flush;

  assign bus.if_valid = (count != 2'd0);
  assign bus.if_instr = buf_instr[b_rp];
  assign bus.if_pc    = buf_pc[b_rp];

  assign dbg_outst = outst;
  assign dbg_count = count;
  assign dbg_drop  = drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst        <= 2'd0;
      count        <= 2'd0;
      drop         <= 2'd0;
      a_wp         <= 1'b0;
      a_rp         <= 1'b0;
      b_wp         <= 1'b0;
      b_rp         <= 1'b0;
      afifo[0]     <= 32'd0;
      afifo[1]     <= 32'd0;
      buf_pc[0]    <= 32'd0;
      buf_pc[1]    <= 32'd0;
      buf_instr[0] <= 32'd0;
      buf_instr[1] <= 32'd0;
    end else begin
      // The address FIFO tracks memory traffic and ignores flush:
      // dropped responses still retire their FIFO entry.
      outst <= outst + {1'b0, grant} - {1'b0, resp};
      if (grant) begin
        afifo[a_wp] <= pc_addr;
        a_wp        <= ~a_wp;
      end
      if (resp) begin
        a_rp <= ~a_rp;
      end

      if (flush) begin
        count <= 2'd0;
        b_wp  <= 1'b0;
        b_rp  <= 1'b0;
        // No grant in a flush cycle, so everything still outstanding
        // after this edge is stale; any earlier drop is a subset of it.
        drop  <= outst - {1'b0, resp};
      end else begin
        if (resp && (drop != 2'd0)) begin
          drop <= drop - 2'd1;
        end
        if (wr) begin
          buf_pc[b_wp]    <= afifo[a_rp];
          buf_instr[b_wp] <= bus.imem_rdata;
          b_wp            <= ~b_wp;
        end
        if (rd) begin
          b_rp <= ~b_rp;
        end
        count <= count + {1'b0, wr} - {1'b0, rd};
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_addr = 32'd0;
  logic        pc_stall;
  logic        flush = 1'b0;
  logic [1:0]  dbg_outst, dbg_count, dbg_drop;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .pc_addr   (pc_addr),
    .pc_stall  (pc_stall),
    .flush     (flush),
    .bus       (bus),
    .dbg_outst (dbg_outst),
    .dbg_count (dbg_count),
    .dbg_drop  (dbg_drop)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          killed;
  } mreq_t;

  mreq_t       mem_q[$];   // memory-side view: granted, response not yet returned
  logic [31:0] exp_q[$];   // live fetches (not flushed), oldest first, until consumed
  logic [31:0] pc;
  int          cyc;
  int          last_due;
  int          lat, p_gnt, p_ready, p_flush, p_spur;
  bit          flush_on_rv;
  bit          rv_real;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int live_mem();
    int n = 0;
    foreach (mem_q[i]) if (!mem_q[i].killed) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst             = 1'b0;
    flush           = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.if_ready    = 1'b1;
    mem_q.delete();
    exp_q.delete();
    pc       = 32'd0;
    pc_addr  = 32'd0;
    last_due = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_if_valid", 32'(bus.if_valid), 32'd0);
      check("rst_if_instr", bus.if_instr, 32'd0);
      check("rst_if_pc", bus.if_pc, 32'd0);
      check("rst_imem_req", 32'(bus.imem_req), 32'd0);
      check("rst_pc_stall", 32'(pc_stall), 32'd1);
      check("rst_count", 32'(dbg_count), 32'd0);
      @(posedge clk); #1;
    end
    // Grant is low here, so the first edge after release grants nothing.
    rst = 1'b1;
  endtask

  task automatic one_cycle();
    int live, buffered, due;
    bit e_valid, e_pop, e_req, e_grant;
    @(posedge clk); #1;
    cyc++;
    rv_real = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word_of(mem_q[0].addr);
      rv_real         = 1'b1;
    end else if (mem_q.size() == 0 && $urandom_range(0, 99) < p_spur) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = $urandom;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
    end
    bus.imem_gnt = ($urandom_range(0, 99) < p_gnt);
    bus.if_ready = ($urandom_range(0, 99) < p_ready);
    flush        = ($urandom_range(0, 99) < p_flush) || (flush_on_rv && rv_real);
    pc_addr      = pc;

    @(negedge clk);
    live     = live_mem();
    buffered = exp_q.size() - live;
    e_valid  = (buffered > 0);
    e_pop    = e_valid && bus.if_ready;
    e_req    = !flush && ((mem_q.size() + buffered - int'(e_pop)) < 2);
    e_grant  = e_req && bus.imem_gnt;

    check("if_valid", 32'(bus.if_valid), 32'(e_valid));
    check("imem_req", 32'(bus.imem_req), 32'(e_req));
    check("pc_stall", 32'(pc_stall), 32'(!flush && !e_grant));
    check("outst", 32'(dbg_outst), 32'(mem_q.size()));
    check("count", 32'(dbg_count), 32'(buffered));
    check("drop", 32'(dbg_drop), 32'(mem_q.size() - live));
    if (e_valid) begin
      check("if_pc", bus.if_pc, exp_q[0]);
      check("if_instr", bus.if_instr, word_of(exp_q[0]));
    end
    if (e_req) check("imem_addr", bus.imem_addr, pc);

    // Advance the model across the coming edge.
    if (e_pop) void'(exp_q.pop_front());
    if (flush) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].killed = 1'b1;
    end
    if (rv_real) void'(mem_q.pop_front());
    if (e_grant) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: pc, due: due, killed: 1'b0});
      exp_q.push_back(pc);
    end
    if (flush) pc = {$urandom_range(0, 16'hFFFF), 2'b00};
    else if (e_grant) pc = pc + 32'd4;
  endtask

  task automatic run(input int n, input int l, input int g, input int r,
                     input int f, input int s, input bit frv);
    lat = l; p_gnt = g; p_ready = r; p_flush = f; p_spur = s; flush_on_rv = frv;
    for (int i = 0; i < n; i++) one_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0;
    lat = 1; p_gnt = 0; p_ready = 100; p_flush = 0; p_spur = 0; flush_on_rv = 1'b0;
    do_reset(2);
    // Streaming at L=1, then a mid-run reset and restart.
    run(20, 1, 100, 100, 0, 0, 1'b0);
    do_reset(3);
    run(20, 1, 100, 100, 0, 0, 1'b0);
    // Backpressure then release.
    do_reset(1);
    run(5, 1, 100, 0, 0, 0, 1'b0);
    run(10, 1, 100, 100, 0, 0, 1'b0);
    // Grant stall.
    run(3, 1, 0, 100, 0, 0, 1'b0);
    run(8, 1, 100, 100, 0, 0, 1'b0);
    // Flushes with long latency, including back-to-back.
    run(40, 3, 100, 100, 15, 0, 1'b0);
    run(3, 3, 100, 100, 100, 0, 1'b0);
    run(15, 3, 100, 100, 0, 0, 1'b0);
    // Flush coinciding with a response.
    run(40, 2, 100, 70, 0, 0, 1'b1);
    // Spurious responses while idle.
    run(10, 1, 0, 100, 0, 60, 1'b0);
    run(20, 1, 60, 100, 0, 40, 1'b0);
    // Random mix.
    for (int k = 0; k < 40; k++) begin
      run(50, $urandom_range(1, 4), $urandom_range(20, 100), $urandom_range(0, 100),
          $urandom_range(0, 12), $urandom_range(0, 30), 1'($urandom_range(0, 1)));
    end
    do_reset(2);
    run(20, 1, 100, 100, 0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly downstream of the program counter and upstream of decode. It turns the PC value into requests on a pipelined req/gnt/rvalid instruction-memory port and holds the PC via `pc_stall` until a request is granted. Returned instructions are paired with their fetch address in a 2-entry buffer and offered to decode over a valid/ready handshake. A `flush` (taken jump) discards everything buffered or in flight.

## Interface
- `DEPTH`, 2: total fetch credits, meaning in-flight requests plus buffered instructions; fixed at 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `pc_addr`  in  32  current PC value.
- `pc_stall`  out  1  hold PC; `= !flush && !(imem_req && imem_gnt)`.
- `flush`  in  1  jump taken this cycle; asserted in the same cycle as the PC's jump enable.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  request address; `= pc_addr`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  instruction available to decode.
- `if_ready`  in  1  decode accepts this cycle.
- `if_instr`  out  32  instruction at buffer head.
- `if_pc`  out  32  fetch address of `if_instr`.

## Operation
State:
- `outst`: in-flight count, 0..2.
- Address FIFO, 2 entries: PCs of granted requests.
- Instruction buffer, 2 entries of {pc, instr}, with `count`.
- `drop`: number of responses still to discard, 0..2.

Request, fetch and pop:
- `pop = if_valid && if_ready`.
- `imem_req = !flush && (outst + count - pop) < DEPTH`. The combinational path from `if_ready` is intentional, for full throughput.
- Grant (`imem_req && imem_gnt`): push `pc_addr` into the address FIFO and increment `outst`. `pc_stall` is low that cycle, so the PC advances.
- `imem_req` low or no grant: `pc_stall` high, and `imem_req` must stay asserted with a stable address until granted unless `flush` occurs.

Responses:
- Memory returns responses in order, no earlier than the cycle after grant.
- On `imem_rvalid`: pop the address FIFO and decrement `outst`.
- If `drop > 0`: discard the word and decrement `drop`.
- Otherwise: write {pc, rdata} into the buffer tail.
- `imem_rvalid` with `outst == 0` is ignored, with no state change.
- The credit rule guarantees the buffer never overflows.

Decode side:
- `if_valid = (count != 0)`.
- `if_instr`/`if_pc` come from the buffer head and stay stable while `if_valid && !if_ready`.
- The buffer pushes and pops in the same cycle; `count` is unchanged.

Flush:
- `imem_req` is forced low and `pc_stall` is forced low, so the PC loads the jump target (stall has priority over jump in the PC).
- Buffer is cleared: `count <= 0`; `if_valid` is low the next cycle.
- `drop <= outst - (imem_rvalid && outst != 0 ? 1 : 0) + drop-adjustment`. Net effect: every response outstanding after this cycle is discarded.
- `pop` in a flush cycle is honoured by decode but irrelevant to the buffer.
- Fetch resumes the cycle after flush from the new `pc_addr`.
- Back-to-back flushes are legal.

Reset (`rst` low), asynchronous:
- `outst`, `count`, `drop` and FIFO pointers go to 0.
- `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `imem_req` = 0.
- `pc_stall` is 1, combinational from `imem_req = 0`, while in reset.
- Responses to requests granted before a mid-operation reset are the memory's responsibility; it must be reset together with this stage.

## Timing
- Grant at cycle N with memory latency L≥1: rvalid at N+L, `if_valid` at N+L+1. No bypass from `imem_rdata` to `if_instr`.
- Steady state with L=1 and `if_ready` held high: one instruction per cycle after 2-cycle fill.
- `gnt` low for k cycles: PC holds k cycles, and `imem_addr` is unchanged across them.
- `flush` at cycle F: `if_valid` = 0 at F+1, first new request at F+1 (address = jump target), first new instruction at F+1+L+1 at the earliest.

## Test plan
- Reset and restart: `rst` low mid-run, then `gnt=1`, L=1, `if_ready=1`, PC 0,4,8… → `if_valid`/`if_instr`/`imem_req` = 0 during reset; after release `if_pc` = 0,4,8 on consecutive cycles from cycle 3, at one instruction per cycle.
- Backpressure: `if_ready=0` for 5 cycles → at most 2 requests granted, `pc_stall` high thereafter, `if_pc` held at 0; release → 0,4 delivered in order with no loss or duplication.
- Grant stall: `gnt=0` for 3 cycles at PC 0x10 → `imem_addr` = 0x10 stable and `pc_stall` = 1 for 3 cycles; grant → `if_pc` = 0x10 exactly once.
- Flush with 2 in flight (L=3): flush at PC 0x20 with target 0x100 → the two late responses are dropped, and the next `if_pc` is 0x100.
- Flush in the same cycle as `imem_rvalid`: that word is discarded, the remaining in-flight word is discarded, and `drop` returns to 0.
- Spurious `imem_rvalid` with `outst=0` → no `if_valid` and no count change.
